// File: rtl/systolic_array_ctrl.sv
// Job sequencer for a systolic array: clears the accumulators, streams K operand
// columns/rows with per-lane skew, waits for the array to drain, then captures results.
module systolic_array_ctrl #(
  parameter int WIDTH      = 16,
  parameter int ARR_HEIGHT = 4,
  parameter int ARR_WIDTH  = 4,
  parameter int K_BITS     = 8,
  parameter int PE_LAT     = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [K_BITS-1:0]                     k_len,
  input  logic [1:0]                            simd_mode,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  a_rd_en,
  output logic                                  b_rd_en,
  output logic [K_BITS-1:0]                     a_rd_addr,
  output logic [K_BITS-1:0]                     b_rd_addr,
  input  logic [ARR_HEIGHT*WIDTH-1:0]           a_rd_data,
  input  logic [ARR_WIDTH*WIDTH-1:0]            b_rd_data,
  output logic                                  arr_clear,
  output logic [ARR_HEIGHT*WIDTH-1:0]           arr_in_a,
  output logic [ARR_WIDTH*WIDTH-1:0]            arr_in_b,
  output logic [1:0]                            arr_simd,
  input  logic [ARR_HEIGHT*ARR_WIDTH*WIDTH-1:0] arr_out_c,
  output logic [ARR_HEIGHT*ARR_WIDTH*WIDTH-1:0] result
);

  localparam int DRAIN_LEN = ARR_HEIGHT + ARR_WIDTH + PE_LAT;
  localparam int D_BITS    = $clog2(DRAIN_LEN + 1);
  localparam logic [D_BITS-1:0] DRAIN_LOAD = D_BITS'(DRAIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                                  state_q, state_d;
  logic [K_BITS-1:0]                       k_len_q, k_len_d;
  logic [K_BITS-1:0]                       k_cnt_q, k_cnt_d;
  logic [D_BITS-1:0]                       drain_q, drain_d;
  logic [1:0]                              simd_q, simd_d;
  logic [ARR_HEIGHT*ARR_WIDTH*WIDTH-1:0]   result_q, result_d;
  logic                                    rd_vld_q, rd_vld_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      k_len_q  <= '0;
      k_cnt_q  <= '0;
      drain_q  <= '0;
      simd_q   <= '0;
      result_q <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_len_q  <= k_len_d;
      k_cnt_q  <= k_cnt_d;
      drain_q  <= drain_d;
      simd_q   <= simd_d;
      result_q <= result_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_len_d  = k_len_q;
    k_cnt_d  = k_cnt_q;
    drain_d  = drain_q;
    simd_d   = simd_q;
    result_d = result_q;
    rd_vld_d = (state_q == S_FEED);
    unique case (state_q)
      S_IDLE: begin
        if (start && (k_len != '0)) begin
          state_d = S_CLEAR;
          k_len_d = k_len;
          simd_d  = simd_mode;
        end
      end
      S_CLEAR: begin
        state_d = S_FEED;
        k_cnt_d = '0;
      end
      S_FEED: begin
        // Terminal compare on K-1 keeps the index from ever wrapping at 2^K_BITS-1.
        if (k_cnt_q == k_len_q - K_BITS'(1)) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          k_cnt_d = k_cnt_q + K_BITS'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) begin
          state_d  = S_DONE;
          result_d = arr_out_c;
        end else begin
          drain_d = drain_q - D_BITS'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign arr_clear = (state_q == S_CLEAR);
  assign a_rd_en   = (state_q == S_FEED);
  assign b_rd_en   = (state_q == S_FEED);
  assign a_rd_addr = (state_q == S_FEED) ? k_cnt_q : '0;
  assign b_rd_addr = (state_q == S_FEED) ? k_cnt_q : '0;
  assign arr_simd  = simd_q;
  assign result    = result_q;

  // Lanes are zeroed at the chain input, so bubbles propagate as zeros through the skew.
  genvar gi;
  generate
    for (gi = 0; gi < ARR_HEIGHT; gi++) begin : g_a_lane
      logic [WIDTH-1:0] lane_in;
      assign lane_in = rd_vld_q ? a_rd_data[gi*WIDTH +: WIDTH] : '0;
      if (gi == 0) begin : g_direct
        assign arr_in_a[gi*WIDTH +: WIDTH] = lane_in;
      end else begin : g_skew
        logic [WIDTH-1:0] skew_q [gi];
        logic [WIDTH-1:0] skew_d [gi];
        always_comb begin
          skew_d[0] = lane_in;
          for (int s = 1; s < gi; s++) skew_d[s] = skew_q[s-1];
        end
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            for (int s = 0; s < gi; s++) skew_q[s] <= '0;
          end else begin
            for (int s = 0; s < gi; s++) skew_q[s] <= skew_d[s];
          end
        end
        assign arr_in_a[gi*WIDTH +: WIDTH] = skew_q[gi-1];
      end
    end

    for (gi = 0; gi < ARR_WIDTH; gi++) begin : g_b_lane
      logic [WIDTH-1:0] lane_in;
      assign lane_in = rd_vld_q ? b_rd_data[gi*WIDTH +: WIDTH] : '0;
      if (gi == 0) begin : g_direct
        assign arr_in_b[gi*WIDTH +: WIDTH] = lane_in;
      end else begin : g_skew
        logic [WIDTH-1:0] skew_q [gi];
        logic [WIDTH-1:0] skew_d [gi];
        always_comb begin
          skew_d[0] = lane_in;
          for (int s = 1; s < gi; s++) skew_d[s] = skew_q[s-1];
        end
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            for (int s = 0; s < gi; s++) skew_q[s] <= '0;
          end else begin
            for (int s = 0; s < gi; s++) skew_q[s] <= skew_d[s];
          end
        end
        assign arr_in_b[gi*WIDTH +: WIDTH] = skew_q[gi-1];
      end
    end
  endgenerate

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Scoreboard bench for systolic_array_ctrl: buffer and array models driven by the bench,
// expected done cycles and captured results queued at stimulus time and checked on output.
module tb_systolic_array_ctrl;

  localparam int W  = 16;
  localparam int H  = 4;
  localparam int AW = 4;
  localparam int KB = 8;
  localparam int PL = 1;
  localparam int D  = H + AW + PL;

  logic              clk;
  logic              reset;
  logic              start;
  logic [KB-1:0]     k_len;
  logic [1:0]        simd_mode;
  logic              busy;
  logic              done;
  logic              a_rd_en;
  logic              b_rd_en;
  logic [KB-1:0]     a_rd_addr;
  logic [KB-1:0]     b_rd_addr;
  logic [H*W-1:0]    a_rd_data;
  logic [AW*W-1:0]   b_rd_data;
  logic              arr_clear;
  logic [H*W-1:0]    arr_in_a;
  logic [AW*W-1:0]   arr_in_b;
  logic [1:0]        arr_simd;
  logic [H*AW*W-1:0] arr_out_c;
  logic [H*AW*W-1:0] result;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [15:0] cnt = 16'd0;

  int                exp_done_q[$];
  logic [H*AW*W-1:0] exp_res_q[$];

  systolic_array_ctrl #(
    .WIDTH(W), .ARR_HEIGHT(H), .ARR_WIDTH(AW), .K_BITS(KB), .PE_LAT(PL)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len), .simd_mode(simd_mode),
    .busy(busy), .done(done),
    .a_rd_en(a_rd_en), .b_rd_en(b_rd_en), .a_rd_addr(a_rd_addr), .b_rd_addr(b_rd_addr),
    .a_rd_data(a_rd_data), .b_rd_data(b_rd_data),
    .arr_clear(arr_clear), .arr_in_a(arr_in_a), .arr_in_b(arr_in_b), .arr_simd(arr_simd),
    .arr_out_c(arr_out_c), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] a_val(input int i, input int k);
    return W'(32'h1000 * (i + 1) + k + 1);
  endfunction

  function automatic logic [W-1:0] b_val(input int j, input int k);
    return W'(32'h8000 + 32'h1000 * j + k + 1);
  endfunction

  // Operand buffers with one-cycle registered read; garbage when not strobed.
  always @(posedge clk) begin
    for (int i = 0; i < H; i++)
      a_rd_data[i*W +: W] <= a_rd_en ? a_val(i, int'(a_rd_addr)) : 16'hDEAD;
    for (int j = 0; j < AW; j++)
      b_rd_data[j*W +: W] <= b_rd_en ? b_val(j, int'(b_rd_addr)) : 16'hBEEF;
  end

  // Array output modelled as a free-running registered counter.
  always @(posedge clk) begin
    cnt <= cnt + 16'd1;
    cyc <= cyc + 1;
  end
  assign arr_out_c = {(H*AW){cnt}};

  initial begin
    #200000;
    $display("FAIL watchdog actual=time_limit_reached required=finish");
    $fatal(1, "watchdog");
  end

  // Starts a job from IDLE (called just after a falling edge) and checks every cycle
  // until one cycle past done. Optionally pulses start during FEED and during DONE.
  task automatic run_job(input int k, input logic [1:0] mode, input bit poke_feed, input bit poke_done);
    int t0;
    int kk;
    int exp_cyc;
    logic          exp_feed;
    logic [KB-1:0] exp_addr;
    logic [W-1:0]  exp_lane;
    logic [H*AW*W-1:0] exp_res;
    start = 1'b1;
    k_len = KB'(k);
    simd_mode = mode;
    exp_done_q.push_back(cyc + 2 + k + D);
    @(negedge clk);
    t0 = cyc;
    start = 1'b0;
    for (int o = 0; o <= k + D + 2; o++) begin
      if (o > 0) @(negedge clk);
      start = 1'b0;
      if ((poke_feed && o == 1) || (poke_done && o == k + D + 1)) begin
        start = 1'b1;
        k_len = KB'(3);
        simd_mode = ~mode;
      end
      exp_feed = (o >= 1 && o <= k);
      exp_addr = exp_feed ? KB'(o - 1) : '0;

      n_tests++;
      if (arr_clear !== (o == 0)) begin
        n_fail++;
        $display("FAIL arr_clear o=%0d actual=%b required=%b", o, arr_clear, (o == 0));
      end
      n_tests++;
      if ({a_rd_en, b_rd_en} !== {exp_feed, exp_feed}) begin
        n_fail++;
        $display("FAIL rd_en o=%0d actual=%b%b required=%b", o, a_rd_en, b_rd_en, exp_feed);
      end
      n_tests++;
      if (a_rd_addr !== exp_addr || b_rd_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL rd_addr o=%0d actual=%0d/%0d required=%0d", o, a_rd_addr, b_rd_addr, exp_addr);
      end
      n_tests++;
      if (busy !== (o <= k + D + 1)) begin
        n_fail++;
        $display("FAIL busy o=%0d actual=%b required=%b", o, busy, (o <= k + D + 1));
      end
      n_tests++;
      if (arr_simd !== mode) begin
        n_fail++;
        $display("FAIL arr_simd o=%0d actual=%b required=%b", o, arr_simd, mode);
      end
      n_tests++;
      if (done !== (o == k + D + 1)) begin
        n_fail++;
        $display("FAIL done_level o=%0d actual=%b required=%b", o, done, (o == k + D + 1));
      end
      if (done === 1'b1) begin
        n_tests++;
        if (exp_done_q.size() == 0) begin
          n_fail++;
          $display("FAIL done_extra cycle=%0d actual=done required=no_done", cyc);
        end else begin
          exp_cyc = exp_done_q.pop_front();
          if (cyc !== exp_cyc) begin
            n_fail++;
            $display("FAIL done_cycle actual=%0d required=%0d", cyc, exp_cyc);
          end
        end
      end
      for (int i = 0; i < H; i++) begin
        kk = o - 2 - i;
        exp_lane = (kk >= 0 && kk < k) ? a_val(i, kk) : '0;
        n_tests++;
        if (arr_in_a[i*W +: W] !== exp_lane) begin
          n_fail++;
          $display("FAIL arr_in_a lane%0d o=%0d actual=%h required=%h", i, o, arr_in_a[i*W +: W], exp_lane);
        end
      end
      for (int j = 0; j < AW; j++) begin
        kk = o - 2 - j;
        exp_lane = (kk >= 0 && kk < k) ? b_val(j, kk) : '0;
        n_tests++;
        if (arr_in_b[j*W +: W] !== exp_lane) begin
          n_fail++;
          $display("FAIL arr_in_b lane%0d o=%0d actual=%h required=%h", j, o, arr_in_b[j*W +: W], exp_lane);
        end
      end
      if (o == k + D) exp_res_q.push_back(arr_out_c);
      if (o == k + D + 1 && exp_res_q.size() != 0) begin
        exp_res = exp_res_q[0];
        n_tests++;
        if (result !== exp_res) begin
          n_fail++;
          $display("FAIL result_capture actual=%h required=%h", result, exp_res);
        end
      end
      if (o == k + D + 2 && exp_res_q.size() != 0) begin
        exp_res = exp_res_q.pop_front();
        n_tests++;
        if (result !== exp_res) begin
          n_fail++;
          $display("FAIL result_hold actual=%h required=%h", result, exp_res);
        end
      end
    end
    n_tests++;
    if (exp_done_q.size() != 0) begin
      n_fail++;
      $display("FAIL done_missing actual=%0d_pending required=0", exp_done_q.size());
    end
    exp_done_q.delete();
    exp_res_q.delete();
    $display("[TB] job k=%0d mode=%b started cycle %0d result=%h", k, mode, t0, result[15:0]);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy, done, a_rd_en, b_rd_en, arr_clear} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl actual=%b required=00000", {busy, done, a_rd_en, b_rd_en, arr_clear});
    end
    n_tests++;
    if ({a_rd_addr, b_rd_addr, arr_simd} !== '0 || arr_in_a !== '0 || arr_in_b !== '0 || result !== '0) begin
      n_fail++;
      $display("FAIL reset_data actual=%h/%h/%b/%h/%h required=0", a_rd_addr, b_rd_addr, arr_simd, arr_in_a, arr_in_b);
    end
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle actual=%b required=0", busy);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_basic();
    run_job(8, 2'b01, 1'b0, 1'b0);
  endtask

  task automatic test_zero_len();
    start = 1'b1;
    k_len = '0;
    simd_mode = 2'b11;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      n_tests++;
      if ({busy, done, arr_clear, a_rd_en} !== 4'b0 || a_rd_addr !== '0) begin
        n_fail++;
        $display("FAIL zero_len c=%0d actual=%b addr=%0d required=0000 addr=0", c, {busy, done, arr_clear, a_rd_en}, a_rd_addr);
      end
      n_tests++;
      if (arr_simd !== 2'b01) begin
        n_fail++;
        $display("FAIL zero_len_simd c=%0d actual=%b required=01", c, arr_simd);
      end
    end
    $display("[TB] zero-length start ignored");
  endtask

  task automatic test_ignored_start();
    run_job(5, 2'b10, 1'b1, 1'b1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_tests++;
      if ({busy, done} !== 2'b00) begin
        n_fail++;
        $display("FAIL ignored_start_idle c=%0d actual=%b required=00", c, {busy, done});
      end
    end
  endtask

  task automatic test_back_to_back();
    run_job(4, 2'b11, 1'b0, 1'b0);
    run_job(4, 2'b11, 1'b0, 1'b0);
  endtask

  task automatic test_max_len();
    run_job(255, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    k_len = KB'(3);
    simd_mode = 2'b10;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_busy actual=%b required=1", busy);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if ({busy, done, a_rd_en, b_rd_en, arr_clear} !== 5'b0 || arr_simd !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid_ctrl actual=%b simd=%b required=00000 simd=00", {busy, done, a_rd_en, b_rd_en, arr_clear}, arr_simd);
    end
    n_tests++;
    if (arr_in_a !== '0 || arr_in_b !== '0 || result !== '0 || a_rd_addr !== '0 || b_rd_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_data actual=%h/%h/%h required=0", arr_in_a, arr_in_b, result);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_tests++;
      if ({busy, done} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_mid_hold c=%0d actual=%b required=00", c, {busy, done});
      end
    end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if ({busy, done} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_mid_nodone c=%0d actual=%b required=00", c, {busy, done});
      end
    end
    $display("[TB] job aborted by reset");
    run_job(1, 2'b01, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    k_len = '0;
    simd_mode = 2'b00;
    test_reset();
    test_basic();
    test_zero_len();
    test_ignored_start();
    test_back_to_back();
    test_max_len();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_array_ctrl.md
SYSTOLIC_ARRAY_CTRL -- requirements
Module: systolic_array_ctrl

Interface
REQ-001 Parameters SHALL be:
- WIDTH, default 16, operand lane width.
- ARR_HEIGHT, default 4, array rows (A lanes).
- ARR_WIDTH, default 4, array columns (B lanes).
- K_BITS, default 8, width of reduction-length counter.
- PE_LAT, default 1, per-PE register stages.

REQ-002 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  job request, sampled in IDLE.
- k_len  in  K_BITS  reduction length K, sampled with start.
- simd_mode  in  2  SIMD mode, sampled with start.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- a_rd_en, b_rd_en  out  1  operand buffer read strobes.
- a_rd_addr, b_rd_addr  out  K_BITS  operand index k.
- a_rd_data  in  ARR_HEIGHT*WIDTH  A column k, valid 1 cycle after a_rd_en.
- b_rd_data  in  ARR_WIDTH*WIDTH  B row k, valid 1 cycle after b_rd_en.
- arr_clear  out  1  array accumulator clear, drives array reset.
- arr_in_a  out  ARR_HEIGHT*WIDTH  skewed west-edge operands.
- arr_in_b  out  ARR_WIDTH*WIDTH  skewed north-edge operands.
- arr_simd  out  2  SIMD_control to array.
- arr_out_c  in  ARR_HEIGHT*ARR_WIDTH*WIDTH  array results.
- result  out  ARR_HEIGHT*ARR_WIDTH*WIDTH  captured results.

REQ-003 Reset SHALL be asynchronous and active-high on port reset, and the design SHALL use the single clock clk.

Function
REQ-004 The FSM SHALL have the states IDLE, CLEAR, FEED, DRAIN and DONE.

REQ-005 IDLE SHALL transition to CLEAR when start=1 and k_len!=0, latching k_len into K and simd_mode into arr_simd.

REQ-006 In IDLE, start with k_len=0 SHALL be ignored: no state change and no done.

REQ-007 start SHALL be ignored while busy=1.

REQ-008 CLEAR SHALL last exactly 1 cycle with arr_clear=1, then go to FEED; arr_clear SHALL be 0 in all other states.

REQ-009 FEED SHALL last K cycles; in FEED cycle k (k=0..K-1), a_rd_en=b_rd_en=1 and a_rd_addr=b_rd_addr=k.

REQ-010 Read strobes SHALL be 0 outside FEED, and the addresses SHALL hold 0 outside FEED.

REQ-011 Lane i of A data for index k SHALL appear on arr_in_a lane i exactly i cycles after a_rd_data carries it, via a per-lane delay chain of length i; lane 0 is undelayed.

REQ-012 Lane j of arr_in_b SHALL be delayed by j cycles, in the same way as REQ-011.

REQ-013 Any lane carrying no valid k data (before first, after last) SHALL be driven 0.

REQ-014 DRAIN SHALL last exactly D = ARR_HEIGHT+ARR_WIDTH+PE_LAT cycles, counted by a down-counter, then go to DONE.

REQ-015 On entry to DONE, result SHALL load arr_out_c; result SHALL otherwise hold its value.

REQ-016 DONE SHALL last 1 cycle with done=1, then go to IDLE; a start in the DONE cycle SHALL be ignored.

REQ-017 With start accepted at edge t0, done SHALL be high in cycle t0+2+K+D.

REQ-018 The K counter SHALL not wrap: k_len=2^K_BITS-1 feeds indices 0..2^K_BITS-2 exactly once.

REQ-019 arr_simd SHALL hold the latched mode from CLEAR through DONE, and SHALL retain it in IDLE.

Reset
REQ-020 On reset=1, the block SHALL enter IDLE asynchronously.

REQ-021 On reset=1, busy, done, rd_en, arr_clear, all addresses, arr_in_a, arr_in_b, all skew registers, result and arr_simd SHALL go to 0.

REQ-022 Reset asserted mid-job SHALL abort the job with no done pulse, and the first start after deassertion SHALL run normally.

Verification
REQ-023 Default parameters, start with k_len=8 and simd_mode=2'b01 at t0 -> arr_clear high at t0+1, rd_en high t0+2..t0+9, done at t0+19, arr_simd=01 throughout.

REQ-024 a_rd_data lanes set to {k,k,k,k} for each k -> arr_in_a lane i shows k at cycle t0+3+k+i and 0 otherwise; b lanes behave identically.

REQ-025 Model arr_out_c as a registered counter -> result equals the counter value at the cycle done rises, and result is stable afterwards.

REQ-026 start with k_len=0, and separately start pulsed during FEED and during DONE -> no state change, no extra done, addresses unaffected.

REQ-027 Assert reset during DRAIN -> all outputs 0 the same cycle, no done; then a new start with k_len=1 -> done at t0+12.

REQ-028 Two back-to-back jobs, the second start issued the cycle after done -> the second job's timing is identical to the first.
